// File: rtl/sequential_to_simultaneous_reg_pkg.sv
// Shared definitions for the BCH shift-register stages: output FSM states and
// the width/guard helper functions used to size counters.
package sequential_to_simultaneous_reg_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Maps a zero-valued parameter to 1 so that "0" behaves as "every strobe".
    function automatic int notBeingZero(input int value);
        return (value == 0) ? 1 : value;
    endfunction

    // Bits needed to hold the value n (minimum 1).
    function automatic int bitWidthCal(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if (n >= (1 << i)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sequential_to_simultaneous_reg_clk_distance_counter.sv
// Strobe decimator: passes every CLK_DISTANCE-th enabled strobe as dis_en.
// Shared with the upstream simultaneous-to-sequential stage.
module clk_distance_counter
    import sequential_to_simultaneous_reg_pkg::*;
#(
    parameter int CLK_DISTANCE = 1
) (
    input  logic clk,
    input  logic Srst,
    input  logic init,
    input  logic en,
    input  logic sft_en,
    output logic dis_en
);

    localparam int D  = notBeingZero(CLK_DISTANCE);
    localparam int DW = bitWidthCal(D - 1);

    logic [DW-1:0] r_dc;
    logic          w_last;
    logic          w_step;

    assign w_last = (r_dc == DW'(D - 1));
    assign w_step = en & sft_en & ~init;
    assign dis_en = w_step & w_last;

    always_ff @(posedge clk) begin
        if (Srst) begin
            r_dc <= '0;
        end else if (en & init) begin
            r_dc <= '0;
        end else if (w_step) begin
            r_dc <= w_last ? '0 : r_dc + DW'(1);
        end
    end

endmodule

// File: rtl/sequential_to_simultaneous_reg.sv
// Serial-to-parallel collector: gathers BIT_WIDTH symbols into a SHIFT_LEN word,
// held in a double-buffered output register with a valid/read handshake.
module sequential_to_simultaneous_reg
    import sequential_to_simultaneous_reg_pkg::*;
#(
    parameter int DIRECTION    = 1,
    parameter int SHIFT_LEN    = 4,
    parameter int BIT_WIDTH    = 2,
    parameter int CLK_DISTANCE = 1
) (
    input  logic                                  clk,
    input  logic                                  in_ctr_Srst,
    input  logic                                  in_ctr_init,
    input  logic                                  in_ctr_en,
    input  logic                                  in_ctr_sft_en,
    input  logic                                  in_ctr_rd,
    input  logic [BIT_WIDTH-1:0]                  in,
    output logic [BIT_WIDTH*SHIFT_LEN-1:0]        out,
    output logic                                  out_valid,
    output logic [bitWidthCal(SHIFT_LEN)-1:0]     out_cnt,
    output logic                                  out_ovf
);

    localparam int CW = bitWidthCal(SHIFT_LEN);

    logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] r_shift;
    logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] w_shift_nxt;
    logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] r_out;
    logic [CW-1:0]                       r_cnt;
    logic                                r_ovf;
    logic                                w_acc;
    logic                                w_complete;
    logic                                w_init;
    out_state_t                          r_state;
    out_state_t                          w_state_nxt;

    clk_distance_counter #(
        .CLK_DISTANCE (CLK_DISTANCE)
    ) u_dc (
        .clk    (clk),
        .Srst   (in_ctr_Srst),
        .init   (in_ctr_init),
        .en     (in_ctr_en),
        .sft_en (in_ctr_sft_en),
        .dis_en (w_acc)
    );

    assign w_init     = in_ctr_en & in_ctr_init;
    assign w_complete = w_acc & (r_cnt == CW'(SHIFT_LEN - 1));

    // The completing word is taken from this view so out already contains the last symbol.
    always_comb begin
        w_shift_nxt = r_shift;
        if (DIRECTION > 0) begin
            for (int i = SHIFT_LEN - 1; i > 0; i--) begin
                w_shift_nxt[i] = r_shift[i-1];
            end
            w_shift_nxt[0] = in;
        end else begin
            for (int i = 0; i < SHIFT_LEN - 1; i++) begin
                w_shift_nxt[i] = r_shift[i+1];
            end
            w_shift_nxt[SHIFT_LEN-1] = in;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_init) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_acc) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_complete ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_complete) w_state_nxt = ST_FULL;
            ST_FULL:  if (in_ctr_rd & ~w_complete) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_FULL);
    end

    // A completed word overwrites out only if the slot is free or being read now.
    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            r_out <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_complete & ((r_state == ST_EMPTY) | in_ctr_rd)) begin
                r_out <= w_shift_nxt;
            end
            if (w_init) begin
                r_ovf <= 1'b0;
            end else if (w_complete & (r_state == ST_FULL) & ~in_ctr_rd) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign out     = r_out;
    assign out_cnt = r_cnt;
    assign out_ovf = r_ovf;

endmodule

// File: tb/tb_sequential_to_simultaneous_reg.sv
// Directed bench for sequential_to_simultaneous_reg: both directions and a
// decimated (CLK_DISTANCE=2) instance share one stimulus bus.
module tb_sequential_to_simultaneous_reg;

    logic       clk = 1'b0;
    logic       srst = 1'b0;
    logic       init = 1'b0;
    logic       en = 1'b1;
    logic       sft = 1'b0;
    logic       rd = 1'b0;
    logic [1:0] din = '0;

    logic [7:0] out_a, out_b, out_c;
    logic       vld_a, vld_b, vld_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;
    logic       ovf_a, ovf_b, ovf_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sequential_to_simultaneous_reg #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(2), .CLK_DISTANCE(1)) u_dir1 (
        .clk(clk), .in_ctr_Srst(srst), .in_ctr_init(init), .in_ctr_en(en), .in_ctr_sft_en(sft),
        .in_ctr_rd(rd), .in(din), .out(out_a), .out_valid(vld_a), .out_cnt(cnt_a), .out_ovf(ovf_a));

    sequential_to_simultaneous_reg #(.DIRECTION(0), .SHIFT_LEN(4), .BIT_WIDTH(2), .CLK_DISTANCE(1)) u_dir0 (
        .clk(clk), .in_ctr_Srst(srst), .in_ctr_init(init), .in_ctr_en(en), .in_ctr_sft_en(sft),
        .in_ctr_rd(rd), .in(din), .out(out_b), .out_valid(vld_b), .out_cnt(cnt_b), .out_ovf(ovf_b));

    sequential_to_simultaneous_reg #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(2), .CLK_DISTANCE(2)) u_d2 (
        .clk(clk), .in_ctr_Srst(srst), .in_ctr_init(init), .in_ctr_en(en), .in_ctr_sft_en(sft),
        .in_ctr_rd(rd), .in(din), .out(out_c), .out_valid(vld_c), .out_cnt(cnt_c), .out_ovf(ovf_c));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] v);
        din = v;
        sft = 1'b1;
        tick();
        sft = 1'b0;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    task automatic frame(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
        strobe(a); strobe(b); strobe(c); strobe(d);
    endtask

    logic [2:0] exp_cnt_seq [7];

    initial begin
        // reset state
        do_reset();
        chk("rst_out", out_a, 8'h00);
        chk("rst_vld", vld_a, 1'b0);
        chk("rst_cnt", cnt_a, 3'd0);
        chk("rst_ovf", ovf_a, 1'b0);

        // basic frame, both directions, with count progression
        strobe(2'd3); chk("cnt1", cnt_a, 3'd1);
        strobe(2'd2); chk("cnt2", cnt_a, 3'd2);
        strobe(2'd1); chk("cnt3", cnt_a, 3'd3);
        chk("vld_before_last", vld_a, 1'b0);
        strobe(2'd0);
        chk("dir1_out", out_a, 8'hE4);
        chk("dir0_out", out_b, 8'h1B);
        chk("dir1_vld", vld_a, 1'b1);
        chk("dir1_cnt0", cnt_a, 3'd0);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("rd_vld", vld_a, 1'b0);
        chk("rd_keeps_out", out_a, 8'hE4);

        // loopback ordering of word 8'hA7
        do_reset();
        frame(2'd2, 2'd2, 2'd1, 2'd3);
        chk("loop_dir1", out_a, 8'hA7);
        do_reset();
        frame(2'd3, 2'd1, 2'd2, 2'd2);
        chk("loop_dir0", out_b, 8'hA7);

        // overflow: second word dropped
        do_reset();
        frame(2'd3, 2'd2, 2'd1, 2'd0);
        frame(2'd0, 2'd0, 2'd0, 2'd1);
        chk("ovf_out", out_a, 8'hE4);
        chk("ovf_flag", ovf_a, 1'b1);
        chk("ovf_vld", vld_a, 1'b1);

        // read coincident with completion: new word loaded, no overflow
        do_reset();
        frame(2'd3, 2'd2, 2'd1, 2'd0);
        strobe(2'd0); strobe(2'd0); strobe(2'd0);
        rd = 1'b1; strobe(2'd1); rd = 1'b0;
        chk("rdc_out", out_a, 8'h01);
        chk("rdc_vld", vld_a, 1'b1);
        chk("rdc_ovf", ovf_a, 1'b0);

        // decimation by 2: values 1,3,1,3 sampled
        do_reset();
        for (int i = 0; i < 8; i++) begin
            strobe(2'(i % 4));
        end
        chk("d2_out", out_c, 8'h77);
        chk("d2_vld", vld_c, 1'b1);

        // partial frame discarded by init; init-cycle symbol dropped
        exp_cnt_seq = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        do_reset();
        strobe(2'd2); chk("p_cnt0", cnt_a, exp_cnt_seq[0]);
        strobe(2'd2); chk("p_cnt1", cnt_a, exp_cnt_seq[1]);
        init = 1'b1; strobe(2'd3); init = 1'b0;
        chk("p_cnt2", cnt_a, exp_cnt_seq[2]);
        for (int i = 3; i < 7; i++) begin
            strobe(2'd1);
            chk($sformatf("p_cnt%0d", i), cnt_a, exp_cnt_seq[i]);
        end
        chk("p_out_dir1", out_a, 8'h55);
        chk("p_out_dir0", out_b, 8'h55);
        chk("p_vld", vld_a, 1'b1);

        // reset while FULL with overflow and mid-frame
        do_reset();
        frame(2'd3, 2'd2, 2'd1, 2'd0);
        frame(2'd1, 2'd1, 2'd1, 2'd1);
        strobe(2'd1); strobe(2'd1); strobe(2'd1);
        chk("pre_srst_cnt", cnt_a, 3'd3);
        chk("pre_srst_ovf", ovf_a, 1'b1);
        do_reset();
        chk("srst_out", out_a, 8'h00);
        chk("srst_vld", vld_a, 1'b0);
        chk("srst_cnt", cnt_a, 3'd0);
        chk("srst_ovf", ovf_a, 1'b0);

        // enable low: strobes and init ignored, read still honoured
        strobe(2'd2); strobe(2'd2);
        en = 1'b0;
        strobe(2'd3); strobe(2'd3);
        init = 1'b1; tick(); init = 1'b0;
        chk("en0_cnt", cnt_a, 3'd2);
        en = 1'b1;
        strobe(2'd0); strobe(2'd1);
        chk("en0_out", out_a, 8'hA1);
        en = 1'b0;
        rd = 1'b1; tick(); rd = 1'b0;
        chk("en0_rd_vld", vld_a, 1'b0);
        en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
